// File: rtl/cos_seq_ctrl.sv
// cos_seq_ctrl
// Control sequencer for the cosine Maclaurin datapath. Accepts a request on
// start/x_in, walks the datapath through LOAD, MAX_TERMS rounds of
// (MULX, MULC, ACC) and FIN, then captures the accumulator and pulses done.
// Any mismatch between the datapath's terminal count (cnt8) and the local
// iteration count is reported on the sticky err flag.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start, x_in        request strobe and operand (sampled when busy=0)
//   busy, done         operation in progress / one-cycle result-valid pulse
//   result, err        captured accumulator / protocol error for last request
//   xBus               latched operand driven to the datapath
//   ldX, init0, initT1, initC1, cntUp, ldT, ldC, selXR
//                      datapath control strobes (selXR: 0 = x^2, 1 = LUT)
//   cnt8, rBus         datapath terminal-count flag and accumulator value
module cos_seq_ctrl #(
    parameter int X_W       = 16,
    parameter int R_W       = 18,
    parameter int MAX_TERMS = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [X_W-1:0] x_in,
    output logic           busy,
    output logic           done,
    output logic [R_W-1:0] result,
    output logic           err,
    output logic [X_W-1:0] xBus,
    output logic           ldX,
    output logic           init0,
    output logic           initT1,
    output logic           initC1,
    output logic           cntUp,
    output logic           ldT,
    output logic           ldC,
    output logic           selXR,
    input  logic           cnt8,
    input  logic [R_W-1:0] rBus
);

    localparam int ITR_W = $clog2(MAX_TERMS) + 1;
    localparam logic [ITR_W-1:0] LAST_ITR = ITR_W'(MAX_TERMS - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MULX,
        MULC,
        ACC,
        FIN
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [X_W-1:0]   x_hold;
    logic [ITR_W-1:0] itr;

    logic last_itr;
    assign last_itr = (itr == LAST_ITR);

    // State register plus the request-side registers. done is registered off
    // FIN so it appears in the cycle after FIN, together with busy=0 and the
    // freshly captured result. In ACC, err is raised whenever cnt8 and the
    // local iteration count disagree: early cnt8, or cnt8 missing when the
    // watchdog count is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            x_hold <= '0;
            itr    <= '0;
            err    <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            state <= state_next;
            done  <= (state == FIN);
            case (state)
                IDLE: begin
                    if (start) begin
                        x_hold <= x_in;
                        err    <= 1'b0;
                        itr    <= '0;
                    end
                end
                ACC: begin
                    itr <= itr + ITR_W'(1);
                    if (cnt8 != last_itr) begin
                        err <= 1'b1;
                    end
                end
                FIN: begin
                    result <= rBus;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic and strobe decode. Strobes depend only on the
    // registered state so the datapath sees glitch-free, start-independent
    // controls.
    always_comb begin
        state_next = state;
        ldX        = 1'b0;
        init0      = 1'b0;
        initT1     = 1'b0;
        initC1     = 1'b0;
        cntUp      = 1'b0;
        ldT        = 1'b0;
        ldC        = 1'b0;
        selXR      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                ldX        = 1'b1;
                init0      = 1'b1;
                initT1     = 1'b1;
                initC1     = 1'b1;
                state_next = MULX;
            end
            MULX: begin
                ldT        = 1'b1;
                cntUp      = 1'b1;
                state_next = MULC;
            end
            MULC: begin
                selXR      = 1'b1;
                ldT        = 1'b1;
                state_next = ACC;
            end
            ACC: begin
                ldC = 1'b1;
                // Every terminating condition (normal, early cnt8, watchdog)
                // leads to FIN; only the err update differs.
                if (cnt8 || last_itr) begin
                    state_next = FIN;
                end else begin
                    state_next = MULX;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);
    assign xBus = x_hold;

endmodule

// File: tb/tb_cos_seq_ctrl.sv
// tb_cos_seq_ctrl
// Self-checking bench for cos_seq_ctrl. A stub datapath counts cntUp pulses
// (cleared by init0) and raises cnt8 when that count equals a chosen trigger.
// Expected cycle-by-cycle behaviour is derived from the operation length:
// n rounds of three cycles, framed by LOAD and FIN, with done one cycle later.
module tb_cos_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] x_in = '0;
    logic        busy, done, err;
    logic [17:0] result;
    logic [15:0] xBus;
    logic        ldX, init0, initT1, initC1, cntUp, ldT, ldC, selXR;
    logic        cnt8;
    logic [17:0] rBus = '0;

    int          tests = 0;
    int          fails = 0;
    logic [17:0] prevResult = '0;
    int          stubTrig = 7;
    logic [7:0]  stubCnt = '0;

    typedef struct {
        logic [15:0] x;
        int          trig;
        logic [17:0] rb;
        int          expDone;
        bit          expErr;
    } vec_t;

    vec_t vecs[6];

    cos_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .x_in(x_in),
        .busy(busy), .done(done), .result(result), .err(err), .xBus(xBus),
        .ldX(ldX), .init0(init0), .initT1(initT1), .initC1(initC1),
        .cntUp(cntUp), .ldT(ldT), .ldC(ldC), .selXR(selXR),
        .cnt8(cnt8), .rBus(rBus)
    );

    always #5 clk = ~clk;

    // Stub datapath counter
    always @(posedge clk) begin
        if (init0) stubCnt <= '0;
        else if (cntUp) stubCnt <= stubCnt + 8'd1;
    end
    assign cnt8 = (int'(stubCnt) == stubTrig);

    logic [7:0] strobes;
    assign strobes = {ldX, init0, initT1, initC1, cntUp, ldT, ldC, selXR};

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference: trigger 1..7 ends after that many rounds; anything else
    // never asserts cnt8 and the watchdog ends after 7. Only trigger 7 is clean.
    function automatic void refModel(input int trig, output int expDone, output bit expErr);
        int n;
        n = (trig >= 1 && trig <= 7) ? trig : 7;
        expDone = 3 * n + 3;
        expErr = (trig != 7);
    endfunction

    function automatic logic [7:0] expStrobes(input int c, input int n);
        if (c == 1) return 8'b1111_0000;
        if (c >= 2 && c <= 3 * n + 1) begin
            case ((c - 2) % 3)
                0: return 8'b0000_1100;
                1: return 8'b0000_0101;
                default: return 8'b0000_0010;
            endcase
        end
        return 8'h00;
    endfunction

    task automatic applyStimulus(input logic [15:0] x, input int trig, input logic [17:0] rb,
                                 input int expDone, input bit expErr, input bit disturb,
                                 input int rstAt, input bit chain, input logic [15:0] chainX,
                                 input bit preArmed);
        int n, doneCycle, badCycles, xBad, ups, ldts, doneCount;
        logic [7:0]  eS;
        logic        eBusy, eDone, eErr;
        logic [17:0] eRes;
        n = (expDone - 3) / 3;
        doneCycle = 0; badCycles = 0; xBad = 0; ups = 0; ldts = 0; doneCount = 0;
        stubTrig = trig;
        rBus = rb;
        if (!preArmed) begin
            @(negedge clk);
            start = 1'b1;
            x_in = x;
        end
        @(posedge clk);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            eBusy = (c <= 3 * n + 2);
            eDone = (c == 3 * n + 3);
            eErr  = expErr && (c >= 3 * n + 2);
            eS    = expStrobes(c, n);
            eRes  = (c == 3 * n + 3) ? rb : prevResult;
            if ({busy, done, err, strobes, result} !== {eBusy, eDone, eErr, eS, eRes})
                badCycles++;
            if (xBus !== x) xBad++;
            ups += int'(cntUp);
            ldts += int'(ldT);
            if (c == 1) begin
                start = 1'b0;
                x_in = ~x;
            end
            if (disturb && (c == 5 || c == 10)) begin
                start = 1'b1;
                x_in = 16'($urandom);
            end
            if (disturb && (c == 6 || c == 11)) start = 1'b0;
            if (c == rstAt) begin
                rst = 1'b1;
                break;
            end
            if (done === 1'b1) begin
                doneCycle = c;
                break;
            end
        end
        checkOutput("cycle model mismatches", badCycles, 0);
        checkOutput("xBus held", xBad, 0);
        if (rstAt != 0) begin
            @(negedge clk);
            checkOutput("abort busy", busy, 0);
            checkOutput("abort strobes", strobes, 0);
            checkOutput("abort result", result, 0);
            checkOutput("abort err", err, 0);
            rst = 1'b0;
            prevResult = '0;
            for (int c = 0; c < 30; c++) begin
                if (done === 1'b1) doneCount++;
                @(negedge clk);
            end
            checkOutput("no done after abort", doneCount, 0);
            return;
        end
        checkOutput("done cycle", doneCycle, expDone);
        checkOutput("result", result, rb);
        checkOutput("err", err, expErr);
        checkOutput("cntUp pulses", ups, n);
        checkOutput("ldT pulses", ldts, 2 * n);
        prevResult = rb;
        if (chain) begin
            start = 1'b1;
            x_in = chainX;
        end else begin
            @(negedge clk);
            checkOutput("done one cycle", done, 0);
            checkOutput("result held", result, rb);
            checkOutput("err held", err, expErr);
        end
    endtask

    initial begin
        vecs[0] = '{16'h4000, 7,  18'h2A5A5, 24, 1'b0};
        vecs[1] = '{16'h1111, 4,  18'h01234, 15, 1'b1};
        vecs[2] = '{16'hFFFF, 7,  18'h3FFFF, 24, 1'b0};
        vecs[3] = '{16'h0F0F, 15, 18'h15555, 24, 1'b1};
        vecs[4] = '{16'h8000, 1,  18'h00001, 6,  1'b1};
        vecs[5] = '{16'h0000, 6,  18'h2AAAA, 21, 1'b1};

        repeat (2) @(negedge clk);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset err", err, 0);
        checkOutput("reset result", result, 0);
        checkOutput("reset xBus", xBus, 0);
        checkOutput("reset strobes", strobes, 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            applyStimulus(vecs[i].x, vecs[i].trig, vecs[i].rb, vecs[i].expDone,
                          vecs[i].expErr, 1'b0, 0, 1'b0, 16'h0, 1'b0);

        // Back-to-back: second start held in the done cycle
        applyStimulus(16'h1234, 7, 18'h0BEEF, 24, 1'b0, 1'b0, 0, 1'b1, 16'h8000, 1'b0);
        applyStimulus(16'h8000, 7, 18'h1CAFE, 24, 1'b0, 1'b0, 0, 1'b0, 16'h0, 1'b1);

        // Starts while busy are ignored
        applyStimulus(16'h5A5A, 7, 18'h12345, 24, 1'b0, 1'b1, 0, 1'b0, 16'h0, 1'b0);

        // Early cnt8 sets err; the next accepted start clears it
        applyStimulus(16'h2222, 4, 18'h00777, 15, 1'b1, 1'b0, 0, 1'b0, 16'h0, 1'b0);
        applyStimulus(16'h3333, 7, 18'h00888, 24, 1'b0, 1'b0, 0, 1'b0, 16'h0, 1'b0);

        // Reset in cycle 12 aborts; a new request then completes
        applyStimulus(16'h7777, 7, 18'h31313, 24, 1'b0, 1'b0, 12, 1'b0, 16'h0, 1'b0);
        applyStimulus(16'h6666, 7, 18'h04242, 24, 1'b0, 1'b0, 0, 1'b0, 16'h0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            int  trig, expDone;
            bit  expErr;
            trig = int'($urandom_range(1, 8));
            if (trig == 8) trig = 15;
            refModel(trig, expDone, expErr);
            applyStimulus(16'($urandom), trig, 18'($urandom), expDone, expErr,
                          1'($urandom), 0, 1'b0, 16'h0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
